fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the 16-bit PC.
- Takes the PC's `out` value, issues a read to instruction memory over a req/ack handshake, and latches the returned word into an instruction register presented to decode with a valid/ready handshake.
- Drives the PC's `inc` input, and its `load`/`in` inputs on control-flow redirects.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit_timeout_ctr.sv | 37 +++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int FETCH_DW      = 16;
    localparam int FETCH_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_REQ   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_REDIR = 3'd4,
        ST_KILL  = 3'd5
    } state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// PC, instruction-memory, redirect and decode signals of the fetch stage.
// The master modport is the fetch unit; slave is PC/memory/decode.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int DW = FETCH_DW
) ();

    logic          enable;
    logic [DW-1:0] pc_addr;
    logic          pc_inc;
    logic          pc_load;
    logic [DW-1:0] pc_in;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          redirect;
    logic [DW-1:0] redirect_addr;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          fetch_err;

    modport master (
        input  enable, pc_addr, imem_ack, imem_rdata, redirect, redirect_addr, instr_ready,
        output pc_inc, pc_load, pc_in, imem_req, imem_addr, instr, instr_valid, fetch_err
    );

    modport slave (
        output enable, pc_addr, imem_ack, imem_rdata, redirect, redirect_addr, instr_ready,
        input  pc_inc, pc_load, pc_in, imem_req, imem_addr, instr, instr_valid, fetch_err
    );

endinterface

// File: rtl/fetch_unit_timeout_ctr.sv
// Counts consecutive request cycles without an ack; tc flags the TIMEOUT-th such cycle.
// Combinational tc so the fetch FSM can drop the request on that same edge.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && !clr && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC -> imem read (req/ack) -> instruction register (valid/ready), all outputs registered.
// Data appears two cycles after ISSUE at best; decode stall holds the instruction and blocks new fetches.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DW      = FETCH_DW,
    parameter int TIMEOUT = FETCH_TIMEOUT
) (
    input  logic         clock,
    input  logic         rst,
    fetch_unit_if.master bus
);

    state_t        state_q, state_d;
    logic [DW-1:0] imem_addr_q, imem_addr_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] pc_in_q, pc_in_d;
    logic          imem_req_q, imem_req_d;
    logic          instr_valid_q, instr_valid_d;
    logic          pc_inc_q, pc_inc_d;
    logic          pc_load_q, pc_load_d;
    logic          fetch_err_q, fetch_err_d;

    logic tmo_en;
    logic tmo_tc;
    logic can_fetch;
    logic capture;

    assign tmo_en    = imem_req_q && !bus.imem_ack;
    assign can_fetch = bus.enable && !fetch_err_q;
    // A redirect in the ack cycle makes the returned word stale.
    assign capture   = (state_q == ST_REQ) && bus.imem_ack && !bus.redirect;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clock (clock),
        .rst   (rst),
        .clr   (!tmo_en),
        .en    (tmo_en),
        .tc    (tmo_tc)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            imem_addr_q   <= '0;
            instr_q       <= '0;
            pc_in_q       <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            pc_inc_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            pc_in_q       <= pc_in_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            pc_inc_q      <= pc_inc_d;
            pc_load_q     <= pc_load_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // An outstanding request can never be withdrawn, so a redirect during it parks in KILL.
    always_comb begin
        state_d = state_q;
        if (tmo_tc) begin
            state_d = ST_IDLE;
        end else if (bus.redirect) begin
            state_d = (imem_req_q && !bus.imem_ack) ? ST_KILL : ST_REDIR;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (can_fetch) state_d = ST_ISSUE;
                ST_ISSUE: state_d = ST_REQ;
                ST_REQ:   if (bus.imem_ack) state_d = ST_HOLD;
                ST_HOLD:  if (bus.instr_ready) state_d = can_fetch ? ST_ISSUE : ST_IDLE;
                ST_REDIR: state_d = can_fetch ? ST_ISSUE : ST_IDLE;
                ST_KILL:  if (bus.imem_ack) state_d = can_fetch ? ST_ISSUE : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req_d    = (state_d == ST_REQ) || (state_d == ST_KILL);
        imem_addr_d   = (state_q == ST_ISSUE) ? bus.pc_addr : imem_addr_q;
        instr_d       = capture ? bus.imem_rdata : instr_q;
        pc_inc_d      = capture;
        instr_valid_d = instr_valid_q && !bus.instr_ready;
        if (capture) begin
            instr_valid_d = 1'b1;
        end
        if (bus.redirect || tmo_tc) begin
            instr_valid_d = 1'b0;
        end
        pc_load_d   = bus.redirect;
        pc_in_d     = bus.redirect ? bus.redirect_addr : pc_in_q;
        fetch_err_d = fetch_err_q || tmo_tc;
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc_inc      = pc_inc_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_in       = pc_in_q;
    assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch-unit bench: PC register, memory responder and program-order scoreboard.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int TMO = FETCH_TIMEOUT;

    logic clock = 1'b0;
    logic rst   = 1'b0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [15:0] pc;
    logic [15:0] exp_addr;
    logic [15:0] req_addr;
    logic [15:0] cap_addr;
    logic [15:0] cap_data;
    logic [15:0] prev_instr;
    logic [15:0] prev_target;
    logic [15:0] ovr_dat;
    bit prev_req, prev_ack, prev_vld, prev_ready, prev_redir, prev_capture;
    bit killed, exp_err, no_ack, use_ovr, rand_delay, beef_seen;
    int wait_cnt, ack_delay, noack_run, inc_count, req_rises, vld_cycle;
    logic [15:0] req_log[$];
    logic [15:0] dat_log[$];
    int req_cyc_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        logic [31:0] p;
        p = {16'd0, a} * 32'h9E37;
        return p[15:0] ^ 16'h1234;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b0;
        #1;
        chk("rst_instr", 32'(bus.instr), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_pc_inc", 32'(bus.pc_inc), 32'd0);
        chk("rst_pc_load", 32'(bus.pc_load), 32'd0);
        chk("rst_pc_in", 32'(bus.pc_in), 32'd0);
        chk("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
        prev_req = 0; prev_ack = 0; prev_vld = 0; prev_ready = 0;
        prev_redir = 0; prev_capture = 0; killed = 0;
        exp_err = 0; noack_run = 0; exp_addr = pc;
    endtask

    // One cycle, entered and left at the falling edge: check outputs, answer memory, drive inputs, clock the PC.
    task automatic cyc(input bit rdr, input logic [15:0] tgt, input bit rdy);
        logic req, vld, inc, ld, ack, cap;
        logic [15:0] rdata, pc_next;
        req = bus.imem_req;
        vld = bus.instr_valid;
        inc = bus.pc_inc;
        ld  = bus.pc_load;
        cycle++;

        chk("inc_load_excl", 32'(inc & ld), 32'd0);
        chk("pc_load", 32'(ld), 32'(prev_redir));
        if (prev_redir) chk("pc_in", 32'(bus.pc_in), 32'(prev_target));
        chk("pc_inc", 32'(inc), 32'(prev_capture));
        chk("instr_valid", 32'(vld), 32'(prev_capture || (prev_vld && !prev_ready && !prev_redir)));
        if (prev_capture) begin
            chk("instr_data", 32'(bus.instr), 32'(cap_data));
            dat_log.push_back(bus.instr);
            vld_cycle = cycle;
            exp_addr = cap_addr + 16'd1;
        end else if (prev_vld && vld) begin
            chk("instr_hold", 32'(bus.instr), 32'(prev_instr));
        end
        if (vld && bus.instr == 16'hBEEF) beef_seen = 1;
        chk("req_while_vld", 32'(req & vld), 32'd0);
        chk("fetch_err", 32'(bus.fetch_err), 32'(exp_err));
        if (exp_err || prev_ack) chk("req_low", 32'(req), 32'd0);
        if (inc) inc_count++;

        if (req && !prev_req) begin
            chk("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
            req_addr = bus.imem_addr;
            killed = 0;
            wait_cnt = 0;
            req_log.push_back(bus.imem_addr);
            req_cyc_log.push_back(cycle);
            req_rises++;
            if (rand_delay) ack_delay = $urandom_range(0, 4);
        end else if (req) begin
            chk("imem_addr_stable", 32'(bus.imem_addr), 32'(req_addr));
        end

        ack = req && !no_ack && (wait_cnt >= ack_delay);
        rdata = ack ? (use_ovr ? ovr_dat : mem_f(req_addr)) : 16'($urandom);
        if (req && !ack) wait_cnt++;
        if (req && rdr) killed = 1;
        cap = ack && !killed;
        if (rdr) exp_addr = tgt;
        if (req && !ack) noack_run++; else noack_run = 0;
        pc_next = ld ? bus.pc_in : (inc ? pc + 16'd1 : pc);

        bus.imem_ack      = ack;
        bus.imem_rdata    = rdata;
        bus.redirect      = rdr;
        bus.redirect_addr = rdr ? tgt : 16'($urandom);
        bus.instr_ready   = rdy;

        prev_req = req; prev_ack = ack; prev_vld = vld; prev_ready = rdy;
        prev_redir = rdr; prev_target = tgt; prev_instr = bus.instr;
        prev_capture = cap; cap_addr = req_addr; cap_data = rdata;
        if (noack_run >= TMO) exp_err = 1;

        @(posedge clock);
        #1;
        pc = pc_next;
        bus.pc_addr = pc;
        @(negedge clock);
    endtask

    initial begin
        int r0, i0, d0;
        logic [15:0] held;
        pc = 16'h0000;
        bus.enable = 1'b1;
        bus.pc_addr = pc;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.redirect = 1'b0;
        bus.redirect_addr = 16'h0000;
        bus.instr_ready = 1'b0;
        no_ack = 0; use_ovr = 0; rand_delay = 0; ack_delay = 0; ovr_dat = 16'hBEEF;
        inc_count = 0; req_rises = 0; beef_seen = 0; vld_cycle = 0; wait_cnt = 0;
        @(negedge clock);
        do_reset();

        // Basic fetch from 0 with immediate ack.
        for (int i = 0; i < 40 && req_log.size() < 2; i++) cyc(1'b0, 16'h0, 1'b1);
        chk("t1_two_reqs", 32'(req_log.size()), 32'd2);
        if (req_log.size() >= 2 && dat_log.size() >= 1) begin
            chk("t1_addr0", 32'(req_log[0]), 32'h0000);
            chk("t1_instr", 32'(dat_log[0]), 32'h1234);
            chk("t1_latency", 32'(vld_cycle - req_cyc_log[0]), 32'd1);
            chk("t1_one_inc", 32'(inc_count), 32'd1);
            chk("t1_addr1", 32'(req_log[1]), 32'h0001);
        end

        // Decode stall for 5 cycles.
        for (int i = 0; i < 20 && !bus.instr_valid; i++) cyc(1'b0, 16'h0, 1'b0);
        i0 = inc_count; r0 = req_rises; held = bus.instr;
        repeat (5) cyc(1'b0, 16'h0, 1'b0);
        chk("t2_valid_held", 32'(bus.instr_valid), 32'd1);
        chk("t2_instr_held", 32'(bus.instr), 32'(held));
        chk("t2_one_inc", 32'(inc_count - i0), 32'd1);
        chk("t2_no_req", 32'(req_rises - r0), 32'd0);
        cyc(1'b0, 16'h0, 1'b1);

        // Redirect while holding an instruction.
        for (int i = 0; i < 20 && !bus.instr_valid; i++) cyc(1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0);
        cyc(1'b1, 16'h0040, 1'b0);
        chk("t3_pc_load", 32'(bus.pc_load), 32'd1);
        chk("t3_pc_in", 32'(bus.pc_in), 32'h0040);
        chk("t3_valid_clr", 32'(bus.instr_valid), 32'd0);
        r0 = req_rises;
        for (int i = 0; i < 20 && req_rises == r0; i++) cyc(1'b0, 16'h0, 1'b1);
        chk("t3_next_addr", 32'(req_log[$]), 32'h0040);

        // Redirect during an outstanding request; stale data returns later.
        ack_delay = 4; use_ovr = 1;
        r0 = req_rises;
        for (int i = 0; i < 20 && req_rises == r0; i++) cyc(1'b0, 16'h0, 1'b1);
        beef_seen = 0; i0 = inc_count;
        cyc(1'b1, 16'h0100, 1'b1);
        for (int i = 0; i < 10 && !prev_ack; i++) cyc(1'b0, 16'h0, 1'b1);
        use_ovr = 0; ack_delay = 0;
        r0 = req_rises;
        for (int i = 0; i < 20 && req_rises == r0; i++) cyc(1'b0, 16'h0, 1'b1);
        chk("t4_next_addr", 32'(req_log[$]), 32'h0100);
        chk("t4_no_beef", 32'(beef_seen), 32'd0);
        chk("t4_no_inc", 32'(inc_count - i0), 32'd0);

        // Redirect in the same cycle as the ack.
        for (int i = 0; i < 20 && !bus.imem_req; i++) cyc(1'b0, 16'h0, 1'b1);
        i0 = inc_count;
        cyc(1'b1, 16'h0200, 1'b1);
        chk("t5_pc_load", 32'(bus.pc_load), 32'd1);
        chk("t5_valid", 32'(bus.instr_valid), 32'd0);
        r0 = req_rises;
        for (int i = 0; i < 20 && req_rises == r0; i++) cyc(1'b0, 16'h0, 1'b1);
        chk("t5_next_addr", 32'(req_log[$]), 32'h0200);
        chk("t5_no_inc", 32'(inc_count - i0), 32'd0);

        // Random traffic: ack delays, decode stalls and redirects.
        rand_delay = 1;
        d0 = dat_log.size();
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 9) == 0, 16'($urandom), $urandom_range(0, 2) != 0);
        end
        chk("rand_progress", 32'(dat_log.size() > d0 + 100), 32'd1);

        // enable low: in-flight work drains, nothing new issues.
        rand_delay = 0; ack_delay = 1;
        bus.enable = 1'b0;
        repeat (15) cyc(1'b0, 16'h0, 1'b1);
        r0 = req_rises;
        repeat (15) cyc(1'b0, 16'h0, 1'b1);
        chk("en_off_no_req", 32'(req_rises - r0), 32'd0);
        bus.enable = 1'b1;
        for (int i = 0; i < 10 && req_rises == r0; i++) cyc(1'b0, 16'h0, 1'b1);
        chk("en_on_resume", 32'(req_rises - r0), 32'd1);

        // Memory never answers.
        no_ack = 1;
        for (int i = 0; i < 40 && !bus.fetch_err; i++) cyc(1'b0, 16'h0, 1'b1);
        chk("tmo_err", 32'(bus.fetch_err), 32'd1);
        chk("tmo_req_drop", 32'(bus.imem_req), 32'd0);
        no_ack = 0;
        r0 = req_rises;
        repeat (10) cyc(1'b0, 16'h0, 1'b1);
        chk("tmo_idle", 32'(req_rises - r0), 32'd0);
        chk("tmo_sticky", 32'(bus.fetch_err), 32'd1);
        do_reset();
        d0 = dat_log.size();
        for (int i = 0; i < 20 && dat_log.size() == d0; i++) cyc(1'b0, 16'h0, 1'b1);
        chk("post_rst_fetch", 32'(dat_log.size() - d0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
